// File: rtl/serial_adder_nbit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_nbit_pkg : shared state encoding for the serial adder    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package serial_adder_nbit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adder_fa_1bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_fa_1bit : combinational full adder from two half adders + OR    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module adder_fa_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha0_sum;
    logic ha0_cout;
    logic ha1_cout;

    adder_ha_1bit u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (ha0_sum),
        .cout (ha0_cout)
    );

    adder_ha_1bit u_ha1 (
        .a    (ha0_sum),
        .b    (cin),
        .sum  (sum),
        .cout (ha1_cout)
    );

    // The two half-adder carries can never both be set, so OR gives majority.
    assign cout = ha0_cout | ha1_cout;

endmodule
`default_nettype wire

// File: rtl/adder_ha_1bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_ha_1bit : combinational 1-bit half adder                        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module adder_ha_1bit (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule
`default_nettype wire

// File: rtl/serial_adder_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_nbit : LSB-first bit-serial WIDTH-bit adder, one FA cell |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_adder_nbit
    import serial_adder_nbit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;

    adder_fa_1bit u_fa (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at LSB.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_next = fa_sum;
        end else begin : g_sum_wn
            assign sum_next = {fa_sum, sum_reg[WIDTH-1:1]};
        end
    endgenerate

    assign accept = in_valid && (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_RUN;
            S_RUN:  if (cnt == CNT_LAST) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            shift_a <= in_a;
            shift_b <= in_b;
            sum_reg <= '0;
            carry   <= in_cin;
            cnt     <= '0;
        end else if (state == S_RUN) begin
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            sum_reg <= sum_next;
            carry   <= fa_cout;
            cnt     <= cnt + 1'b1;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign out_sum   = sum_reg;
    assign out_cout  = carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_adder_nbit : scoreboard bench for WIDTH=8, 1 and 13 builds  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_serial_adder_nbit;

    logic        clk;
    logic        rst;
    logic [2:0]  vld;
    logic [2:0]  cin;
    logic [2:0]  ordy;
    logic [63:0] opa [3];
    logic [63:0] opb [3];
    wire  [2:0]  irdy;
    wire  [2:0]  ovld;
    wire  [2:0]  cout;
    wire  [2:0]  bsy;
    wire  [7:0]  s8;
    wire  [0:0]  s1;
    wire  [12:0] s13;

    int checks = 0;
    int errors = 0;
    logic [64:0] sb [$];

    serial_adder_nbit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(irdy[0]),
        .in_a(opa[0][7:0]), .in_b(opb[0][7:0]), .in_cin(cin[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .out_sum(s8),
        .out_cout(cout[0]), .busy(bsy[0])
    );

    serial_adder_nbit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(irdy[1]),
        .in_a(opa[1][0:0]), .in_b(opb[1][0:0]), .in_cin(cin[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .out_sum(s1),
        .out_cout(cout[1]), .busy(bsy[1])
    );

    serial_adder_nbit #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(irdy[2]),
        .in_a(opa[2][12:0]), .in_b(opb[2][12:0]), .in_cin(cin[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .out_sum(s13),
        .out_cout(cout[2]), .busy(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wd(int i);
        case (i)
            0:       return 8;
            1:       return 1;
            default: return 13;
        endcase
    endfunction

    function automatic logic [64:0] model(int i, logic [63:0] a, logic [63:0] b, logic c);
        logic [64:0] m;
        logic [64:0] r;
        m = (65'd1 << wd(i)) - 65'd1;
        r = ({1'b0, a} & m) + ({1'b0, b} & m) + 65'(c);
        return r & ((65'd1 << (wd(i) + 1)) - 65'd1);
    endfunction

    function automatic logic [64:0] res(int i);
        case (i)
            0:       return {56'd0, cout[0], s8};
            1:       return {63'd0, cout[1], s1};
            default: return {51'd0, cout[2], s13};
        endcase
    endfunction

    task automatic check(string tag, logic [64:0] obs, logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_accept(int i, logic [63:0] a, logic [63:0] b, logic c, int gap);
        int n;
        n = 0;
        for (int g = 0; g < gap; g++) begin
            ordy[i] = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_no_valid", 65'(ovld[i]), 65'd0);
        end
        opa[i] = a;
        opb[i] = b;
        cin[i] = c;
        vld[i] = 1'b1;
        while (!irdy[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_seen", 65'(irdy[i]), 65'd1);
        @(negedge clk);
        vld[i] = 1'b0;
        opa[i] = ~a;
        opb[i] = ~b;
        cin[i] = ~c;
        sb.push_back(model(i, a, b, c));
        check("busy_after_accept", 65'(bsy[i]), 65'd1);
    endtask

    task automatic wait_result(int i, int hold, bit poke);
        int k;
        logic [64:0] exp;
        k = 0;
        ordy[i] = (hold == 0);
        while (!ovld[i] && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("out_valid_seen", 65'(ovld[i]), 65'd1);
        check("latency", 65'(k + 1), 65'(wd(i) + 1));
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        check("result", res(i), exp);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                opa[i] = 64'hAA;
                opb[i] = 64'h55;
                cin[i] = 1'b0;
                vld[i] = (h % 2 == 0);
            end
            @(negedge clk);
            check("hold_valid", 65'(ovld[i]), 65'd1);
            check("hold_ready", 65'(irdy[i]), 65'd0);
            check("hold_result", res(i), exp);
        end
        vld[i]  = 1'b0;
        ordy[i] = 1'b1;
        @(negedge clk);
        check("valid_drop", 65'(ovld[i]), 65'd0);
        check("idle_ready", 65'(irdy[i]), 65'd1);
        check("result_kept", res(i), exp);
    endtask

    initial begin
        rst  = 1'b1;
        vld  = '0;
        cin  = '0;
        ordy = '1;
        for (int i = 0; i < 3; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 65'(irdy[i]), 65'd1);
            check("rst_out_valid", 65'(ovld[i]), 65'd0);
            check("rst_result", res(i), 65'd0);
            check("rst_busy", 65'(bsy[i]), 65'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed WIDTH=8 operations
        do_accept(0, 64'h5A, 64'h3C, 1'b0, 0);
        wait_result(0, 0, 1'b0);
        do_accept(0, 64'hFF, 64'h01, 1'b0, 0);
        wait_result(0, 0, 1'b0);
        do_accept(0, 64'hFF, 64'hFF, 1'b1, 1);
        wait_result(0, 0, 1'b0);

        // Backpressure with ignored requests while DONE
        do_accept(0, 64'h12, 64'h34, 1'b0, 0);
        wait_result(0, 5, 1'b1);
        check("post_hold_busy", 65'(bsy[0]), 65'd0);
        do_accept(0, 64'hAA, 64'h55, 1'b0, 0);
        wait_result(0, 0, 1'b0);

        // Asynchronous reset in the middle of RUN
        do_accept(0, 64'h80, 64'h80, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_rst_in_ready", 65'(irdy[0]), 65'd1);
        check("midrun_rst_out_valid", 65'(ovld[0]), 65'd0);
        check("midrun_rst_result", res(0), 65'd0);
        check("midrun_rst_busy", 65'(bsy[0]), 65'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("no_stale_valid", 65'(ovld[0]), 65'd0);
        end
        do_accept(0, 64'h80, 64'h80, 1'b0, 0);
        wait_result(0, 0, 1'b0);

        // WIDTH=1 full-adder truth table
        for (int c = 0; c < 8; c++) begin
            do_accept(1, 64'((c >> 2) & 1), 64'((c >> 1) & 1), 1'(c & 1), c % 2);
            wait_result(1, c % 3, 1'b0);
        end

        // Random regression on WIDTH=8 and WIDTH=13
        for (int i = 0; i < 3; i += 2) begin
            repeat (1000) begin
                do_accept(i, {$urandom, $urandom}, {$urandom, $urandom},
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
                wait_result(i, int'($urandom_range(0, 3)), 1'b0);
            end
        end
        check("scoreboard_empty", 65'(sb.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
